axi4s_pkt_tx: RTL and testbench

Packet transmitter for the packet buffer: accepts a descriptor (start address, length in beats), reads the packet out of the buffer's synchronous RAM read port, and drives it onto an AXI4-Stream master interface with `tlast` on the final beat. Sits between the packet-buffer RAM and the downstream stream consumer. Sustains one beat per cycle under continuous `s_tready_i` despite the RAM's 1-cycle read latency, and never drops or duplicates beats under backpressure.

---
 rtl/axi4s_pkg.sv | 22 ++
 rtl/axi4s_pkt_tx_outbuf.sv | 78 +++++++
 rtl/axi4s_pkt_tx.sv | 114 +++++++++++
 tb/tb_axi4s_pkt_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4s_pkg.sv
// rtl/axi4s_pkg.sv - shared types and read-credit helper for the AXI4-Stream packet transmitter
package axi4s_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } tx_state_t;

   // Output buffer holds the output register plus one skid entry.
   localparam logic [2:0] OUTBUF_DEPTH = 3'd2;

   // A new read may issue only if every beat already committed (buffered or
   // in flight), less the one leaving this cycle, still leaves a free slot.
   function automatic logic credit_ok(input logic [1:0] count,
                                      input logic       in_flight,
                                      input logic       pop);
      logic [2:0] used;
      used = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
      return used < OUTBUF_DEPTH;
   endfunction

endpackage

// File: rtl/axi4s_pkt_tx_outbuf.sv
// rtl/axi4s_pkt_tx_outbuf.sv - 2-entry output buffer (output register + skid) for the stream master
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   push_data_i/last_i/valid_i        beat returning from the RAM read
//   s_tdata_o/tvalid_o/tlast_o        oldest buffered beat, held until accepted
//   s_tready_i                        downstream ready
//   count_o                           beats held (0..2), feeds the read credit check
module axi4s_pkt_tx_outbuf
   import axi4s_pkg::*;
#(
   parameter int AXI_WIDTH = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AXI_WIDTH-1:0] push_data_i,
   input  logic                 push_last_i,
   input  logic                 push_valid_i,
   output logic [AXI_WIDTH-1:0] s_tdata_o,
   output logic                 s_tvalid_o,
   output logic                 s_tlast_o,
   input  logic                 s_tready_i,
   output logic [1:0]           count_o
);

   typedef struct packed {
      logic [AXI_WIDTH-1:0] data;
      logic                 last;
   } axi4s_beat_t;

   axi4s_beat_t out_q, out_d, skid_q, skid_d, push_beat;
   logic        out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
   logic        pop;

   always_comb begin
      push_beat  = {push_data_i, push_last_i};
      pop        = out_vld_q & s_tready_i;
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!out_vld_q || pop) begin
         // Output slot frees up: the skid entry is older than any new push.
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = push_valid_i;
            if (push_valid_i) skid_d = push_beat;
         end else begin
            out_vld_d = push_valid_i;
            if (push_valid_i) out_d = push_beat;
         end
      end else if (push_valid_i) begin
         // Output stalled; the read credit guarantees the skid entry is free here.
         skid_d     = push_beat;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign s_tdata_o  = out_q.data;
   assign s_tlast_o  = out_q.last;
   assign s_tvalid_o = out_vld_q;
   assign count_o    = {1'b0, out_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: rtl/axi4s_pkt_tx.sv
// rtl/axi4s_pkt_tx.sv - packet transmitter: descriptor in, RAM reads out, AXI4-Stream master beats
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   desc_addr_i/len_i/valid_i, desc_ready_o descriptor handshake (start address, length in beats)
//   mem_rd_en_o, mem_rd_addr_o, mem_rd_data_i  synchronous RAM read port (1-cycle latency)
//   s_tdata_o/tvalid_o/tready_i/tlast_o    AXI4-Stream master
//   busy_o                                 packet in progress
//   pkt_done_o                             pulse the cycle after the tlast beat handshakes
module axi4s_pkt_tx
   import axi4s_pkg::*;
#(
   parameter int AXI_WIDTH  = 64,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [ADDR_WIDTH-1:0] desc_addr_i,
   input  logic [LEN_WIDTH-1:0]  desc_len_i,
   input  logic                  desc_valid_i,
   output logic                  desc_ready_o,
   output logic                  mem_rd_en_o,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
   input  logic [AXI_WIDTH-1:0]  mem_rd_data_i,
   output logic [AXI_WIDTH-1:0]  s_tdata_o,
   output logic                  s_tvalid_o,
   input  logic                  s_tready_i,
   output logic                  s_tlast_o,
   output logic                  busy_o,
   output logic                  pkt_done_o
);

   tx_state_t             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  desc_ready_q, desc_ready_d;
   logic                  inflight_vld_q, inflight_vld_d;
   logic                  inflight_last_q, inflight_last_d;
   logic                  done_q, done_d;
   logic [1:0]            buf_count;
   logic                  pop, issue, is_last_rd;

   always_comb begin
      pop             = s_tvalid_o & s_tready_i;
      issue           = (state_q == READ) && credit_ok(buf_count, inflight_vld_q, pop);
      is_last_rd      = (rem_q == LEN_WIDTH'(1));
      state_d         = state_q;
      addr_d          = addr_q;
      rem_d           = rem_q;
      case (state_q)
         IDLE: begin
            // Zero-length descriptors are consumed without leaving IDLE.
            if (desc_valid_i && desc_ready_q && (desc_len_i != '0)) begin
               state_d = READ;
               addr_d  = desc_addr_i;
               rem_d   = desc_len_i;
            end
         end
         READ: begin
            if (issue) begin
               addr_d = addr_q + ADDR_WIDTH'(1);
               rem_d  = rem_q - LEN_WIDTH'(1);
               if (is_last_rd) state_d = IDLE;
            end
         end
      endcase
      inflight_vld_d  = issue;
      inflight_last_d = issue & is_last_rd;
      desc_ready_d    = (state_d == IDLE);
      done_d          = pop & s_tlast_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         rem_q           <= '0;
         desc_ready_q    <= 1'b0;
         inflight_vld_q  <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         rem_q           <= rem_d;
         desc_ready_q    <= desc_ready_d;
         inflight_vld_q  <= inflight_vld_d;
         inflight_last_q <= inflight_last_d;
         done_q          <= done_d;
      end
   end

   axi4s_pkt_tx_outbuf #(
      .AXI_WIDTH (AXI_WIDTH)
   ) u_outbuf (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_data_i  (mem_rd_data_i),
      .push_last_i  (inflight_last_q),
      .push_valid_i (inflight_vld_q),
      .s_tdata_o    (s_tdata_o),
      .s_tvalid_o   (s_tvalid_o),
      .s_tlast_o    (s_tlast_o),
      .s_tready_i   (s_tready_i),
      .count_o      (buf_count)
   );

   assign desc_ready_o  = desc_ready_q;
   assign mem_rd_en_o   = issue;
   assign mem_rd_addr_o = addr_q;
   assign busy_o        = (state_q == READ) | inflight_vld_q | (buf_count != 2'd0);
   assign pkt_done_o    = done_q;

endmodule

// File: tb/tb_axi4s_pkt_tx.sv
// tb/tb_axi4s_pkt_tx.sv - table-driven self-checking bench for axi4s_pkt_tx
module tb_axi4s_pkt_tx;

   localparam int AW  = 64;
   localparam int ADW = 10;
   localparam int LW  = 10;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [ADW-1:0] desc_addr = '0;
   logic [LW-1:0]  desc_len = '0;
   logic           desc_valid = 1'b0;
   logic           desc_ready;
   logic           mem_rd_en;
   logic [ADW-1:0] mem_rd_addr;
   logic [AW-1:0]  mem_rd_data = '0;
   logic [AW-1:0]  s_tdata;
   logic           s_tvalid;
   logic           s_tready = 1'b0;
   logic           s_tlast;
   logic           busy;
   logic           pkt_done;

   always #5 clk = ~clk;

   axi4s_pkt_tx #(.AXI_WIDTH(AW), .ADDR_WIDTH(ADW), .LEN_WIDTH(LW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .desc_addr_i(desc_addr), .desc_len_i(desc_len), .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
      .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
      .s_tdata_o(s_tdata), .s_tvalid_o(s_tvalid), .s_tready_i(s_tready), .s_tlast_o(s_tlast),
      .busy_o(busy), .pkt_done_o(pkt_done)
   );

   // RAM content: every address holds a distinct word.
   function automatic logic [63:0] mem_word(input int a);
      return 64'hD00D_0000_0000_0000 | 64'(a & 1023);
   endfunction

   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_word(int'(mem_rd_addr));

   int nvec = 0;
   int nmis = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Ready driver: random in backpressure mode, else the fixed level.
   bit bp = 1'b0;
   bit rdy_fix = 1'b1;
   initial forever begin
      @(posedge clk);
      #1;
      s_tready = bp ? 1'($urandom_range(0, 1)) : rdy_fix;
   end

   // Monitor: samples at negedge, so a sampled valid&&ready completes at the next posedge.
   int          cyc = 0;
   int          done_cnt = 0, issued = 0, popped = 0, viol = 0;
   logic [63:0] bq_data[$];
   logic        bq_last[$];
   int          bq_cyc[$];
   int          rq_addr[$];
   int          rq_cyc[$];
   int          hs_q[$];
   logic        mon_pop;

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         mon_pop = s_tvalid && s_tready;
         if (mon_pop) begin
            bq_data.push_back(s_tdata);
            bq_last.push_back(s_tlast);
            bq_cyc.push_back(cyc);
         end
         if (mem_rd_en) begin
            if (issued - popped - int'(mon_pop) >= 2) viol++;
            rq_addr.push_back(int'(mem_rd_addr));
            rq_cyc.push_back(cyc);
         end
         issued += int'(mem_rd_en);
         popped += int'(mon_pop);
         if (pkt_done) done_cnt++;
         if (desc_valid && desc_ready) hs_q.push_back(cyc);
      end
   end

   task automatic clear_mon();
      bq_data.delete(); bq_last.delete(); bq_cyc.delete();
      rq_addr.delete(); rq_cyc.delete(); hs_q.delete();
      done_cnt = 0; issued = 0; popped = 0; viol = 0;
   endtask

   task automatic send_desc(input logic [ADW-1:0] a, input logic [LW-1:0] l);
      int t;
      t = 0;
      @(posedge clk);
      #1;
      desc_addr = a; desc_len = l; desc_valid = 1'b1;
      @(negedge clk);
      while (!desc_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("desc_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
      desc_valid = 1'b0;
   endtask

   task automatic wait_pkt(input int n);
      int t;
      t = 0;
      while ((bq_data.size() < n || busy) && t < 300) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (t >= 300) chk("pkt_timeout", 64'd1, 64'd0);
      repeat (4) @(negedge clk);
   endtask

   typedef struct {
      logic [ADW-1:0] addr;
      logic [LW-1:0]  len;
      bit             bp;
      int             exp_beats;
      int             exp_dones;
      int             exp_last_rd;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int   t, n, hs0;
      logic [63:0] exp_d;

      vecs[0] = '{addr: 10'h010, len: 10'd4, bp: 1'b0, exp_beats: 4, exp_dones: 1, exp_last_rd: 'h013};
      vecs[1] = '{addr: 10'h100, len: 10'd8, bp: 1'b1, exp_beats: 8, exp_dones: 1, exp_last_rd: 'h107};
      vecs[2] = '{addr: 10'h3FE, len: 10'd4, bp: 1'b0, exp_beats: 4, exp_dones: 1, exp_last_rd: 'h001};
      vecs[3] = '{addr: 10'h055, len: 10'd1, bp: 1'b0, exp_beats: 1, exp_dones: 1, exp_last_rd: 'h055};
      vecs[4] = '{addr: 10'h200, len: 10'd0, bp: 1'b0, exp_beats: 0, exp_dones: 0, exp_last_rd: 0};
      vecs[5] = '{addr: 10'h3FF, len: 10'd3, bp: 1'b1, exp_beats: 3, exp_dones: 1, exp_last_rd: 'h001};

      // Reset values while rst_n is held low.
      #12;
      chk("rst_desc_ready", 64'(desc_ready), 64'd0);
      chk("rst_rd_en",      64'(mem_rd_en),  64'd0);
      chk("rst_rd_addr",    64'(mem_rd_addr), 64'd0);
      chk("rst_tvalid",     64'(s_tvalid),   64'd0);
      chk("rst_tlast",      64'(s_tlast),    64'd0);
      chk("rst_tdata",      s_tdata,         64'd0);
      chk("rst_busy",       64'(busy),       64'd0);
      chk("rst_done",       64'(pkt_done),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("post_rst_desc_ready", 64'(desc_ready), 64'd1);

      for (int v = 0; v < 6; v++) begin
         clear_mon();
         bp = vecs[v].bp;
         rdy_fix = 1'b1;
         send_desc(vecs[v].addr, vecs[v].len);
         n = vecs[v].exp_beats;
         wait_pkt(n);
         bp = 1'b0;
         chk($sformatf("v%0d_hs", v),    64'(hs_q.size()),    64'd1);
         chk($sformatf("v%0d_beats", v), 64'(bq_data.size()), 64'(n));
         chk($sformatf("v%0d_reads", v), 64'(rq_addr.size()), 64'(n));
         chk($sformatf("v%0d_dones", v), 64'(done_cnt),       64'(vecs[v].exp_dones));
         chk($sformatf("v%0d_credit", v), 64'(viol),          64'd0);
         for (int k = 0; k < n && k < bq_data.size(); k++) begin
            exp_d = mem_word((int'(vecs[v].addr) + k) % 1024);
            chk($sformatf("v%0d_data%0d", v, k), bq_data[k], exp_d);
            chk($sformatf("v%0d_last%0d", v, k), 64'(bq_last[k]), 64'(k == n - 1));
         end
         if (n > 0 && rq_addr.size() > 0)
            chk($sformatf("v%0d_last_rd_addr", v), 64'(rq_addr[rq_addr.size()-1]), 64'(vecs[v].exp_last_rd));
         if (!vecs[v].bp && n > 0 && bq_cyc.size() == n && rq_cyc.size() == n) begin
            hs0 = (hs_q.size() > 0) ? hs_q[0] : -100;
            chk($sformatf("v%0d_rd_lat", v),    64'(rq_cyc[0]), 64'(hs0 + 1));
            chk($sformatf("v%0d_beat_lat", v),  64'(bq_cyc[0]), 64'(hs0 + 3));
            chk($sformatf("v%0d_rd_burst", v),  64'(rq_cyc[n-1]), 64'(rq_cyc[0] + n - 1));
            chk($sformatf("v%0d_bt_burst", v),  64'(bq_cyc[n-1]), 64'(bq_cyc[0] + n - 1));
         end
      end

      // Back-to-back descriptors: len=3 at 0x040 then len=2 at 0x080.
      clear_mon();
      rdy_fix = 1'b1;
      send_desc(10'h040, 10'd3);
      send_desc(10'h080, 10'd2);
      wait_pkt(5);
      chk("b2b_beats", 64'(bq_data.size()), 64'd5);
      chk("b2b_dones", 64'(done_cnt), 64'd2);
      chk("b2b_credit", 64'(viol), 64'd0);
      for (int k = 0; k < 5 && k < bq_data.size(); k++) begin
         exp_d = (k < 3) ? mem_word('h040 + k) : mem_word('h080 + k - 3);
         chk($sformatf("b2b_data%0d", k), bq_data[k], exp_d);
         chk($sformatf("b2b_last%0d", k), 64'(bq_last[k]), 64'(k == 2 || k == 4));
      end
      if (hs_q.size() == 2 && rq_cyc.size() >= 3)
         chk("b2b_ready_gap", 64'(hs_q[1]), 64'(rq_cyc[2] + 1));
      else
         chk("b2b_hs_count", 64'(hs_q.size()), 64'd2);

      // Reset mid-packet with the output stalled and the buffer full.
      clear_mon();
      rdy_fix = 1'b1;
      send_desc(10'h020, 10'd6);
      t = 0;
      while (bq_data.size() < 2 && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (t >= 100) chk("mid_timeout", 64'd1, 64'd0);
      rdy_fix = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("mid_tvalid", 64'(s_tvalid), 64'd1);
      chk("mid_busy",   64'(busy),     64'd1);
      chk("mid_tdata",  s_tdata,       mem_word('h022));
      chk("mid_beats",  64'(bq_data.size()), 64'd2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_desc_ready", 64'(desc_ready), 64'd0);
      chk("arst_rd_en",      64'(mem_rd_en),  64'd0);
      chk("arst_rd_addr",    64'(mem_rd_addr), 64'd0);
      chk("arst_tvalid",     64'(s_tvalid),   64'd0);
      chk("arst_tlast",      64'(s_tlast),    64'd0);
      chk("arst_tdata",      s_tdata,         64'd0);
      chk("arst_busy",       64'(busy),       64'd0);
      chk("arst_done",       64'(pkt_done),   64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rel_desc_ready", 64'(desc_ready), 64'd1);
      chk("rel_tvalid",     64'(s_tvalid),   64'd0);
      clear_mon();
      rdy_fix = 1'b1;
      send_desc(10'h030, 10'd2);
      wait_pkt(2);
      chk("rel_beats", 64'(bq_data.size()), 64'd2);
      chk("rel_dones", 64'(done_cnt), 64'd1);
      for (int k = 0; k < 2 && k < bq_data.size(); k++) begin
         chk($sformatf("rel_data%0d", k), bq_data[k], mem_word('h030 + k));
         chk($sformatf("rel_last%0d", k), 64'(bq_last[k]), 64'(k == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
